gate_truth_checker: RTL

- Self-test stage wrapped around the two-input primitive gate set (and, or, not, nand, nor, xor, xnor).
- Upstream side: drives the shared a/b inputs of all seven gates through every input combination.
- Downstream side: samples the seven gate outputs and compares them against the expected truth table.
- Reports pass/fail, a saturating failing-vector count and a per-gate failure mask; used for bring-up and built-in self-test of the gate library.

---
 rtl/gate_truth_checker.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/gate_truth_checker.sv
// Built-in self-test for the two-input gate library.
// It drives a_out/b_out through 00,01,10,11 and checks y_in against the truth table.
//
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   start           run request, accepted only in IDLE
//   busy, done      activity flag and one-cycle completion pulse
//   pass            last run finished with err_count == 0
//   a_out, b_out    shared inputs of all gates under test
//   y_in[6:0]       and, or, not(a), nand, nor, xor, xnor
//   err_count       failing-vector count, saturating
//   err_mask        sticky per-gate mismatch mask
//
// Optional macro GATE_CHK_FIRST_FAIL_EN adds the outputs first_fail_valid,
// first_fail_vec and first_fail_y, which hold the first failing vector.
module gate_truth_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             a_out,
  output logic             b_out,
  input  logic [6:0]       y_in,
  output logic [ERR_W-1:0] err_count,
  output logic [6:0]       err_mask
`ifdef GATE_CHK_FIRST_FAIL_EN
  ,
  output logic             first_fail_valid,
  output logic [1:0]       first_fail_vec,
  output logic [6:0]       first_fail_y
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);
  localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);

  state_t           state;
  logic [1:0]       v;
  logic [3:0]       cnt;
  logic [6:0]       exp_y;
  logic [6:0]       mismatch;
  logic [ERR_W-1:0] err_nxt;

  always_comb begin
    exp_y = {~(a_out ^ b_out), a_out ^ b_out,
             ~(a_out | b_out), ~(a_out & b_out),
             ~a_out, a_out | b_out, a_out & b_out};
    mismatch = y_in ^ exp_y;
    err_nxt = err_count;
    // One count per failing vector, pinned at all-ones.
    if ((|mismatch) && (err_count != '1))
      err_nxt = err_count + ERR_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      v         <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      a_out     <= 1'b0;
      b_out     <= 1'b0;
      err_count <= '0;
      err_mask  <= '0;
`ifdef GATE_CHK_FIRST_FAIL_EN
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
      first_fail_y     <= '0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            err_count <= '0;
            err_mask  <= '0;
            pass      <= 1'b0;
            v         <= '0;
            a_out     <= 1'b0;
            b_out     <= 1'b0;
            busy      <= 1'b1;
            state     <= DRIVE;
`ifdef GATE_CHK_FIRST_FAIL_EN
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
            first_fail_y     <= '0;
`endif
          end
        end
        DRIVE: begin
          cnt   <= SETTLE_LD;
          state <= (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
        end
        SETTLE: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1)
            state <= SAMPLE;
        end
        SAMPLE: begin
          err_mask  <= err_mask | mismatch;
          err_count <= err_nxt;
`ifdef GATE_CHK_FIRST_FAIL_EN
          if ((|mismatch) && !first_fail_valid) begin
            first_fail_valid <= 1'b1;
            first_fail_vec   <= v;
            first_fail_y     <= y_in;
          end
`endif
          if (v == 2'd3) begin
            // pass uses the count including this final vector.
            pass  <= (err_nxt == '0);
            done  <= 1'b1;
            a_out <= 1'b0;
            b_out <= 1'b0;
            state <= DONE;
          end else begin
            v              <= v + 2'd1;
            {a_out, b_out} <= v + 2'd1;
            state          <= DRIVE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
